// File: rtl/mic_sample_framer.sv
// Microphone sample framer: box-car decimate, scale, pack as complex (imag = 0), FIFO-buffer, tag frames.
// Optional build macro MIC_DC_REMOVE_EN removes the 2048 mid-scale offset and uses a signed path.
module mic_sample_framer #(
    parameter int WIDTH      = 32,
    parameter int DECIM_LOG2 = 2,
    parameter int SHIFT      = 5,
    parameter int FIFO_DEPTH = 8,
    parameter int FRAME_LEN  = 256
) (
    input  logic                        adc_clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [11:0]                 adc_sample,
    input  logic                        adc_valid,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int HALF        = WIDTH / 2;
    localparam int CNT_W       = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int LVL_W       = PTR_W + 1;
    localparam int FRM_W       = $clog2(FRAME_LEN);
    localparam int TOTAL_SHIFT = DECIM_LOG2 + SHIFT;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((1 << DECIM_LOG2) - 1);
    localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(FRAME_LEN - 1);
    localparam logic [LVL_W-1:0] LEVEL_FULL = LVL_W'(FIFO_DEPTH);

    logic [HALF-1:0] res_next;

`ifdef MIC_DC_REMOVE_EN
    localparam int ACC_W = 13 + DECIM_LOG2;

    logic signed [12:0]      sample_dc;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] acc_shifted;

    always_comb begin
        sample_dc   = $signed({1'b0, adc_sample}) - 13'sd2048;
        acc_sum     = acc_q + ACC_W'(sample_dc);
        acc_shifted = acc_sum >>> TOTAL_SHIFT;
        res_next    = HALF'(acc_shifted);
    end
`else
    localparam int ACC_W = 12 + DECIM_LOG2;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_sum;
    logic [ACC_W-1:0] acc_shifted;

    always_comb begin
        acc_sum     = acc_q + ACC_W'(adc_sample);
        acc_shifted = acc_sum >> TOTAL_SHIFT;
        res_next    = HALF'(acc_shifted);
    end
`endif

    logic [CNT_W-1:0] cnt_q;
    logic [HALF-1:0]  res_q;
    logic             res_valid_q;

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            if (!enable) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else if (adc_valid) begin
                if (cnt_q == CNT_LAST) begin
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    res_q       <= res_next;
                    res_valid_q <= 1'b1;
                end else begin
                    acc_q <= acc_sum;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    logic [HALF:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_ptr_adv;
    logic [LVL_W-1:0]   count_q;
    logic [LVL_W-1:0]   remain;
    logic [FRM_W-1:0]   frm_q;
    logic [HALF-1:0]    out_real_q;
    logic               pop;
    logic               push;
    logic               full;

    // The output register only sees entries already stored before this edge, which
    // gives the extra cycle of latency and keeps the head stable while stalled.
    always_comb begin
        pop        = out_valid & out_ready;
        full       = (count_q == LEVEL_FULL);
        push       = res_valid_q & (~full | pop);
        rd_ptr_adv = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        remain     = pop ? count_q - LVL_W'(1) : count_q;
    end

    always_ff @(posedge adc_clk) begin
        if (push) begin
            mem[wr_ptr] <= {(frm_q == FRM_LAST), res_q};
        end
    end

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            frm_q      <= '0;
            overflow   <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_real_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                frm_q  <= (frm_q == FRM_LAST) ? '0 : frm_q + FRM_W'(1);
            end
            if (res_valid_q && !push) begin
                overflow <= 1'b1;
            end
            rd_ptr <= rd_ptr_adv;
            case ({push, pop})
                2'b10:   count_q <= count_q + LVL_W'(1);
                2'b01:   count_q <= count_q - LVL_W'(1);
                default: count_q <= count_q;
            endcase
            out_valid <= (remain != '0);
            if (remain != '0) begin
                {out_last, out_real_q} <= mem[rd_ptr_adv];
            end
        end
    end

    assign out_data   = {{(WIDTH - HALF){1'b0}}, out_real_q};
    assign fifo_level = count_q;

endmodule

// File: tb/tb_mic_sample_framer.sv
// Directed bench for mic_sample_framer: two instances (decimating, and FRAME_LEN=4 pass-through).
module tb_mic_sample_framer;
    logic adc_clk = 1'b0;
    always #5 adc_clk = ~adc_clk;

    logic        reset_a, enable_a, adc_valid_a, out_ready_a;
    logic [11:0] sample_a;
    logic [31:0] data_a;
    logic        valid_a, last_a, ovf_a;
    logic [3:0]  level_a;

    logic        reset_b, enable_b, adc_valid_b, out_ready_b;
    logic [11:0] sample_b;
    logic [31:0] data_b;
    logic        valid_b, last_b, ovf_b;
    logic [3:0]  level_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] seen_a[$];
    logic [31:0] seen_b[$];
    logic        seen_last_b[$];

    mic_sample_framer #(
        .WIDTH(32), .DECIM_LOG2(2), .SHIFT(5), .FIFO_DEPTH(8), .FRAME_LEN(256)
    ) u_dut_a (
        .adc_clk(adc_clk), .reset(reset_a), .enable(enable_a),
        .adc_sample(sample_a), .adc_valid(adc_valid_a),
        .out_data(data_a), .out_valid(valid_a), .out_ready(out_ready_a),
        .out_last(last_a), .overflow(ovf_a), .fifo_level(level_a)
    );

    mic_sample_framer #(
        .WIDTH(32), .DECIM_LOG2(0), .SHIFT(0), .FIFO_DEPTH(8), .FRAME_LEN(4)
    ) u_dut_b (
        .adc_clk(adc_clk), .reset(reset_b), .enable(enable_b),
        .adc_sample(sample_b), .adc_valid(adc_valid_b),
        .out_data(data_b), .out_valid(valid_b), .out_ready(out_ready_b),
        .out_last(last_b), .overflow(ovf_b), .fifo_level(level_b)
    );

    // Words are logged just before the edge on which they are handed over.
    task automatic tick();
        if (valid_a && out_ready_a) seen_a.push_back(data_a);
        if (valid_b && out_ready_b) begin
            seen_b.push_back(data_b);
            seen_last_b.push_back(last_b);
        end
        @(posedge adc_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic feed_group_a(input logic [11:0] x);
        enable_a    = 1'b1;
        adc_valid_a = 1'b1;
        sample_a    = x;
        repeat (4) tick();
        adc_valid_a = 1'b0;
    endtask

    initial begin
        reset_a = 1'b1; enable_a = 1'b0; adc_valid_a = 1'b0; out_ready_a = 1'b0; sample_a = '0;
        reset_b = 1'b1; enable_b = 1'b0; adc_valid_b = 1'b0; out_ready_b = 1'b0; sample_b = '0;
        tick();
        tick();
        reset_a = 1'b0;
        reset_b = 1'b0;

        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_last", 32'(last_a), 32'd0);
        check("rst_ovf", 32'(ovf_a), 32'd0);
        check("rst_level", 32'(level_a), 32'd0);
        check("rst_data", data_a, 32'd0);

`ifdef MIC_DC_REMOVE_EN
        out_ready_b = 1'b1; enable_b = 1'b1; adc_valid_b = 1'b1;
        sample_b = 12'd0;    tick();
        sample_b = 12'd4095; tick();
        adc_valid_b = 1'b0;
        repeat (5) tick();
        check("dc_count", 32'(seen_b.size()), 32'd2);
        check("dc_min", (seen_b.size() > 0) ? seen_b[0] : 32'hDEADBEEF, 32'h0000F800);
        check("dc_max", (seen_b.size() > 1) ? seen_b[1] : 32'hDEADBEEF, 32'h000007FF);
`else
        // Latency: 4 x 4000 -> 16000 >> 7 = 125
        out_ready_a = 1'b1;
        feed_group_a(12'd4000);
        tick();
        check("lat_e1_valid", 32'(valid_a), 32'd0);
        check("lat_e1_level", 32'(level_a), 32'd1);
        tick();
        check("lat_e2_valid", 32'(valid_a), 32'd1);
        check("lat_data", data_a, 32'h0000007D);
        check("lat_last", 32'(last_a), 32'd0);
        tick();
        check("lat_drained_valid", 32'(valid_a), 32'd0);
        check("lat_drained_level", 32'(level_a), 32'd0);
        check("lat_words", 32'(seen_a.size()), 32'd1);

        // Partial group discarded by enable=0
        seen_a.delete();
        enable_a = 1'b1; adc_valid_a = 1'b1; sample_a = 12'd1000;
        repeat (3) tick();
        enable_a = 1'b0;
        tick();
        enable_a = 1'b1; sample_a = 12'd128;
        repeat (4) tick();
        adc_valid_a = 1'b0;
        repeat (5) tick();
        check("discard_words", 32'(seen_a.size()), 32'd1);
        check("discard_value", (seen_a.size() > 0) ? seen_a[0] : 32'hDEADBEEF, 32'd4);

        // Fill FIFO with values 1..8 while stalled
        reset_a = 1'b1; tick(); reset_a = 1'b0;
        seen_a.delete();
        out_ready_a = 1'b0;
        for (int g = 1; g <= 8; g++) feed_group_a(12'(32 * g));
        repeat (3) tick();
        check("full_level", 32'(level_a), 32'd8);
        check("full_ovf", 32'(ovf_a), 32'd0);
        check("full_head", data_a, 32'd1);

        // Push of word 9 on the same edge as the pop of word 1
        enable_a = 1'b1; adc_valid_a = 1'b1; sample_a = 12'(32 * 9);
        repeat (4) tick();
        adc_valid_a = 1'b0;
        out_ready_a = 1'b1;
        tick();
        out_ready_a = 1'b0;
        check("pushpop_level", 32'(level_a), 32'd8);
        check("pushpop_ovf", 32'(ovf_a), 32'd0);
        check("pushpop_head", data_a, 32'd2);
        check("pushpop_valid", 32'(valid_a), 32'd1);

        // Words 10 and 11 dropped
        feed_group_a(12'(32 * 10));
        feed_group_a(12'(32 * 11));
        repeat (3) tick();
        check("drop_level", 32'(level_a), 32'd8);
        check("drop_ovf", 32'(ovf_a), 32'd1);
        repeat (3) begin
            check("stall_data", data_a, 32'd2);
            tick();
        end
        out_ready_a = 1'b1;
        repeat (12) tick();
        out_ready_a = 1'b0;
        check("drain_words", 32'(seen_a.size()), 32'd9);
        for (int i = 0; i < 9; i++)
            check("drain_order", (seen_a.size() > i) ? seen_a[i] : 32'hDEADBEEF, 32'(i + 1));
        check("drain_level", 32'(level_a), 32'd0);
        check("drain_valid", 32'(valid_a), 32'd0);

        // Frame tagging on instance b: values 1..9, last on 4 and 8
        out_ready_b = 1'b1; enable_b = 1'b1; adc_valid_b = 1'b1;
        for (int v = 1; v <= 9; v++) begin
            sample_b = 12'(v);
            tick();
        end
        adc_valid_b = 1'b0;
        repeat (5) tick();
        check("frame_words", 32'(seen_b.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            check("frame_value", (seen_b.size() > i) ? seen_b[i] : 32'hDEADBEEF, 32'(i + 1));
            check("frame_last", (seen_last_b.size() > i) ? 32'(seen_last_b[i]) : 32'hDEADBEEF,
                  32'(i == 3 || i == 7));
        end

        // Reset mid-operation on a: 5 words buffered plus a partial group
        out_ready_a = 1'b0;
        for (int g = 1; g <= 5; g++) feed_group_a(12'(32 * g));
        enable_a = 1'b1; adc_valid_a = 1'b1; sample_a = 12'd4000;
        repeat (2) tick();
        adc_valid_a = 1'b0;
        check("pre_reset_level", 32'(level_a), 32'd5);
        reset_a = 1'b1; tick(); reset_a = 1'b0;
        check("mid_rst_valid", 32'(valid_a), 32'd0);
        check("mid_rst_level", 32'(level_a), 32'd0);
        check("mid_rst_ovf", 32'(ovf_a), 32'd0);
        seen_a.delete();
        out_ready_a = 1'b1;
        feed_group_a(12'd128);
        repeat (5) tick();
        check("post_rst_words", 32'(seen_a.size()), 32'd1);
        check("post_rst_value", (seen_a.size() > 0) ? seen_a[0] : 32'hDEADBEEF, 32'd4);

        // Reset mid-frame on b: next frame's last lands on the 4th word
        out_ready_b = 1'b0; adc_valid_b = 1'b1;
        for (int v = 10; v <= 14; v++) begin
            sample_b = 12'(v);
            tick();
        end
        adc_valid_b = 1'b0;
        repeat (3) tick();
        check("b_pre_reset_level", 32'(level_b), 32'd5);
        reset_b = 1'b1; tick(); reset_b = 1'b0;
        check("b_mid_rst_valid", 32'(valid_b), 32'd0);
        check("b_mid_rst_level", 32'(level_b), 32'd0);
        seen_b.delete();
        seen_last_b.delete();
        out_ready_b = 1'b1; adc_valid_b = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            sample_b = 12'(v);
            tick();
        end
        adc_valid_b = 1'b0;
        repeat (5) tick();
        check("b_post_rst_words", 32'(seen_b.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("b_post_rst_value", (seen_b.size() > i) ? seen_b[i] : 32'hDEADBEEF, 32'(i + 1));
            check("b_post_rst_last", (seen_last_b.size() > i) ? 32'(seen_last_b[i]) : 32'hDEADBEEF,
                  32'(i == 3));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mic_sample_framer.md
Name: mic_sample_framer

Overview:
- Parametrised successor to the single-channel microphone sample path.
- Takes raw 12-bit ADC samples with a valid strobe, box-car decimates by 2^DECIM_LOG2, scales, and packs into a complex word (imag = 0).
- Buffers words in a small FIFO and drives a valid/ready stream into the FFT, with out_last marking every FRAME_LEN-th word.

Parameters:
- WIDTH, 32, output word width; real part in [WIDTH/2-1:0], imaginary part in [WIDTH-1:WIDTH/2]; even, >= 26.
- DECIM_LOG2, 2, log2 of decimation ratio; 0 = no decimation; 0..6.
- SHIFT, 5, extra right shift applied after averaging; 0..11.
- FIFO_DEPTH, 8, FIFO entries; power of two, >= 2.
- FRAME_LEN, 256, words per frame; >= 2.

Ports:
- adc_clk  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  capture enable
- adc_sample  in  12  unsigned ADC code
- adc_valid  in  1  adc_sample valid this cycle
- out_data  out  WIDTH  packed complex sample
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_last  out  1  word is last of frame
- overflow  out  1  sticky: a decimated sample was dropped
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (sampled on the rising edge): accumulator = 0, decim count = 0, FIFO empty, frame count = 0. Outputs: out_valid = 0, out_last = 0, overflow = 0, fifo_level = 0, out_data = 0.
- Accumulator width is 12 + DECIM_LOG2; it never overflows.
- Each cycle with enable=1 and adc_valid=1 adds adc_sample to the accumulator and increments the decim count.
- On the 2^DECIM_LOG2-th sample:
  - result = (acc + sample) >> (DECIM_LOG2 + SHIFT), truncating.
  - Result is registered with valid; accumulator and count return to 0 on the same edge.
- enable=0: accumulator and count are held at 0; adc_valid is ignored. A partial group in progress is discarded. FIFO, output and frame count keep operating.
- Packing: out_data[WIDTH/2-1:0] = result, zero-extended; out_data[WIDTH-1:WIDTH/2] = 0.
- Push: the registered result is written to the FIFO one edge after it is produced.
  - If the FIFO is full and no pop occurs that cycle, the word is dropped and overflow is set.
  - overflow clears only on reset.
  - Push with a simultaneous pop on a full FIFO is accepted; no overflow.
- Latency: with the FIFO empty, the edge capturing the final sample of a group is E; out_valid = 1 in the cycle after edge E+2. There is no empty-FIFO bypass.
- Handshake:
  - Pop occurs when out_valid & out_ready.
  - out_data and out_last are stable while out_valid=1 and out_ready=0.
  - out_valid deasserts only after a pop that empties the FIFO.
- Frame tagging:
  - The frame counter advances on each accepted push; dropped words do not advance it.
  - The word pushed at count FRAME_LEN-1 carries last=1; the counter then wraps to 0.
  - The tag is stored in the FIFO alongside the data.
- fifo_level is the registered occupancy: +1 on push only, -1 on pop only, unchanged on both.
- Reset mid-operation discards everything: FIFO contents, partial accumulation and frame position.

Optional Feature:
- Macro: MIC_DC_REMOVE_EN.
- Defined:
  - 2048 is subtracted from each sample before accumulation; the accumulator is signed, width 13 + DECIM_LOG2.
  - The shift is arithmetic.
  - The result is sign-extended into [WIDTH/2-1:0]; imaginary part stays 0.
- Undefined: unsigned path as above; no subtraction logic is synthesised.

Test Plan:
- DECIM_LOG2=2, SHIFT=5; four samples of 4000 with continuous adc_valid, out_ready=1 -> one word, real = 16000>>7 = 125, out_data=32'h0000007D; out_valid high 2 cycles after the 4th-sample edge.
- Same parameters; 3 samples, then enable=0 for 1 cycle, then 4 samples of 128 -> exactly one word, value 4; partial group discarded.
- out_ready=0 with 10 groups pushed, FIFO_DEPTH=8 -> fifo_level=8, overflow=1, 2 words dropped. Release out_ready -> the first 8 words drain in order; out_data held stable while stalled.
- FRAME_LEN=4, DECIM_LOG2=0, SHIFT=0; samples 1..9 -> out_last high on the words with values 4 and 8 only.
- Full FIFO with simultaneous push and pop -> word accepted, overflow stays 0, fifo_level unchanged.
- MIC_DC_REMOVE_EN defined, DECIM_LOG2=0, SHIFT=0; sample 0 -> real = 16'hF800, imag 0; sample 4095 -> real = 16'h07FF.
- Reset asserted with 5 words buffered and a partial group in progress -> next cycle out_valid=0, fifo_level=0, overflow=0; next frame's out_last lands at a fresh count.
